// File: rtl/rv_branch_pkg.sv
// Package: rv_branch_pkg
// Shared types and constants for branch resolution and the branch history table.
//   redir_state_t : redirect sequencer states
//   BHT_INIT/MAX/MIN : 2-bit saturating counter reset, ceiling and floor values
//   bht_next()    : saturating counter update for one resolved conditional branch
package rv_branch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } redir_state_t;

    localparam logic [1:0] BHT_INIT = 2'b01;
    localparam logic [1:0] BHT_MAX  = 2'b11;
    localparam logic [1:0] BHT_MIN  = 2'b00;

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BHT_MAX) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BHT_MIN) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Module: branch_bht
// Array of 2-bit saturating branch counters.
//   clk, rst_n : clock, asynchronous active-low reset (all entries -> BHT_INIT)
//   rd_idx     : ID-stage read index
//   rd_cnt     : counter at rd_idx (combinational, no write bypass)
//   wr_en      : train the entry at wr_idx this edge
//   wr_idx     : EX-stage write index
//   wr_taken   : resolved direction, +1 when taken, -1 otherwise
module branch_bht
    import rv_branch_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= bht_next(cnt_q[wr_idx], wr_taken);
        end
    end

    // Read sees the pre-write value when ID and EX hit the same entry.
    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Module: branch_redirect_ctrl
// EX-stage branch resolution and PC-redirect sequencer.
//   clk, rst_n           : clock, asynchronous active-low reset
//   id_valid/is_branch/is_jal/pc -> id_pred_taken : ID prediction (BHT or JAL)
//   ex_valid/is_branch/is_jal/is_jalr/pc/pred_taken/taken/target : EX resolution inputs
//   redirect_valid/pc/ready : redirect handshake towards fetch
//   flush_if_id, flush_id_ex : pipeline flushes, asserted for the whole redirect
//   perf_branches        : resolved branch/JAL/JALR count
//   perf_mispredicts     : redirect count
module branch_redirect_ctrl
    import rv_branch_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_jal,
    input  logic [31:0]      id_pc,
    output logic             id_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    redir_state_t     state_q, state_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0] perf_br_q, perf_br_d;
    logic [CNT_W-1:0] perf_mis_q, perf_mis_d;

    logic [IDX_W-1:0] id_idx, ex_idx;
    logic [1:0]       id_cnt;
    logic             resolve;
    logic             mispredict;
    logic             use_target;
    logic             bht_wr;
    logic [31:0]      fall_through;

    // PC bits outside the index field play no part in prediction.
    logic unused_id_pc;
    assign unused_id_pc = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

    assign id_idx = id_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    branch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (id_idx),
        .rd_cnt   (id_cnt),
        .wr_en    (bht_wr),
        .wr_idx   (ex_idx),
        .wr_taken (ex_taken)
    );

    assign id_pred_taken = id_valid & (id_is_jal | (id_is_branch & id_cnt[1]));

    // EX is wrong-path while a redirect is outstanding, so resolve only in IDLE.
    assign resolve    = (state_q == IDLE) & ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    assign mispredict = resolve & (ex_is_jalr | (ex_is_branch & (ex_taken != ex_pred_taken)));
    assign use_target = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_taken);
    assign bht_wr     = resolve & ex_is_branch;
    assign fall_through = ex_pc + 32'd4;

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        perf_br_d  = perf_br_q + CNT_W'(resolve);
        perf_mis_d = perf_mis_q + CNT_W'(mispredict);
        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d    = REDIR;
                    redir_pc_d = use_target ? ex_target : fall_through;
                end
            end
            REDIR: begin
                // redirect_valid is implied by the state, so ready alone completes it.
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            redir_pc_q <= 32'd0;
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign redirect_valid   = (state_q == REDIR);
    assign flush_if_id      = (state_q == REDIR);
    assign flush_id_ex      = (state_q == REDIR);
    assign redirect_pc      = redir_pc_q;
    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus randomized traffic, checked by a
// scoreboard of expected redirect addresses and a behavioural model of the BHT and counters.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_is_branch, id_is_jal;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [31:0] ex_pc;
    logic        ex_pred_taken, ex_taken;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush_if_id, flush_id_ex;
    logic [31:0] perf_branches, perf_mispredicts;

    branch_redirect_ctrl #(
        .BHT_ENTRIES (64),
        .CNT_W       (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_is_jal        (id_is_jal),
        .id_pc            (id_pc),
        .id_pred_taken    (id_pred_taken),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jal        (ex_is_jal),
        .ex_is_jalr       (ex_is_jalr),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int unsigned m_bht [64];
    logic        m_redir;
    logic [31:0] m_br, m_mis;
    logic [31:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_redir = 1'b0;
        m_br    = 32'd0;
        m_mis   = 32'd0;
        exp_q.delete();
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % 64;
    endfunction

    initial begin
        int unsigned ix;
        logic misp;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else if (!m_redir) begin
                if (ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
                    m_br = m_br + 1;
                    ix   = idx_of(ex_pc);
                    misp = ex_is_jalr || (ex_is_branch && (ex_taken != ex_pred_taken));
                    if (ex_is_branch) begin
                        if (ex_taken && m_bht[ix] < 3) m_bht[ix] = m_bht[ix] + 1;
                        else if (!ex_taken && m_bht[ix] > 0) m_bht[ix] = m_bht[ix] - 1;
                    end
                    if (misp) begin
                        m_redir = 1'b1;
                        m_mis   = m_mis + 1;
                        exp_q.push_back((ex_is_jalr || ex_taken) ? ex_target : ex_pc + 32'd4);
                    end
                end
            end else if (redirect_ready) begin
                m_redir = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic exp_pred;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_pred = id_valid && (id_is_jal || (id_is_branch && m_bht[idx_of(id_pc)] >= 2));
                check("mon_id_pred_taken", id_pred_taken, exp_pred);
                check("mon_redirect_valid", redirect_valid, m_redir);
                check("mon_flush_if_id", flush_if_id, m_redir);
                check("mon_flush_id_ex", flush_id_ex, m_redir);
                check("mon_perf_branches", perf_branches, m_br);
                check("mon_perf_mispredicts", perf_mispredicts, m_mis);
                if (m_redir) begin
                    if (exp_q.size() == 0) check("sb_queue_nonempty", 32'd0, 32'd1);
                    else begin
                        check("sb_redirect_pc", redirect_pc, exp_q[0]);
                        if (redirect_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 none, 1 conditional branch, 2 JAL, 3 JALR
    task automatic set_ex(input int kind, input logic [31:0] pc, input logic pred,
                          input logic taken, input logic [31:0] tgt);
        ex_valid      = (kind != 0);
        ex_is_branch  = (kind == 1);
        ex_is_jal     = (kind == 2);
        ex_is_jalr    = (kind == 3);
        ex_pc         = pc;
        ex_pred_taken = pred;
        ex_taken      = taken;
        ex_target     = tgt;
    endtask

    task automatic set_id(input logic v, input logic br, input logic jal, input logic [31:0] pc);
        id_valid     = v;
        id_is_branch = br;
        id_is_jal    = jal;
        id_pc        = pc;
    endtask

    initial begin
        logic [31:0] br_before;
        int          k;
        rst_n = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, 32'd0);
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        redirect_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_redirect_valid", redirect_valid, 32'd0);
        check("rst_perf_branches", perf_branches, 32'd0);

        // BEQ mispredicted taken, single-cycle redirect
        step();
        set_ex(1, 32'h100, 1'b0, 1'b1, 32'h80);
        redirect_ready = 1'b1;
        @(negedge clk);
        check("t2_idle_before", redirect_valid, 32'd0);
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t2_valid", redirect_valid, 32'd1);
        check("t2_pc", redirect_pc, 32'h80);
        check("t2_flush_if_id", flush_if_id, 32'd1);
        check("t2_flush_id_ex", flush_id_ex, 32'd1);
        check("t2_mispredicts", perf_mispredicts, 32'd1);
        step();
        @(negedge clk);
        check("t2_valid_drop", redirect_valid, 32'd0);
        check("t2_flush_drop", flush_if_id, 32'd0);

        // BNE mispredicted not-taken, fetch stalls 3 cycles; wrong-path EX ignored
        step();
        set_ex(1, 32'h200, 1'b1, 1'b0, 32'h999);
        redirect_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 32'h500 + 32'(i * 4), 1'b0, 1'b1, 32'h40);
            redirect_ready = (i == 3);
            @(negedge clk);
            check("t3_valid_held", redirect_valid, 32'd1);
            check("t3_pc_held", redirect_pc, 32'h204);
            check("t3_flush_held", flush_id_ex, 32'd1);
            check("t3_branches_frozen", perf_branches, 32'd2);
            step();
        end
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t3_released", redirect_valid, 32'd0);
        check("t3_mispredicts", perf_mispredicts, 32'd2);

        // BHT training on BLT at 0x40
        step();
        redirect_ready = 1'b1;
        set_id(1'b1, 1'b1, 1'b0, 32'h40);
        set_ex(1, 32'h40, 1'b0, 1'b1, 32'h10);
        @(negedge clk);
        check("t4_pred_initial", id_pred_taken, 32'd0);
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t4_pred_after_first", id_pred_taken, 32'd1);
        step();
        set_ex(1, 32'h40, 1'b1, 1'b1, 32'h10);
        step();
        step();
        set_ex(1, 32'h40, 1'b1, 1'b0, 32'h10);
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t4_saturated_then_nt", id_pred_taken, 32'd1);
        check("t4_nt_redirect_pc", redirect_pc, 32'h44);
        step();
        set_ex(1, 32'h40, 1'b1, 1'b0, 32'h10);
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t4_pred_back_to_nt", id_pred_taken, 32'd0);

        // Same-cycle read and write at index 5
        step();
        set_id(1'b1, 1'b1, 1'b0, 32'h14);
        set_ex(1, 32'h14, 1'b0, 1'b1, 32'h80);
        @(negedge clk);
        check("t6_same_cycle_old", id_pred_taken, 32'd0);
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t6_next_cycle_new", id_pred_taken, 32'd1);

        // JALR always redirects; correctly predicted JAL does not
        step();
        set_ex(3, 32'h300, 1'b1, 1'b0, 32'h1234);
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t5_jalr_valid", redirect_valid, 32'd1);
        check("t5_jalr_pc", redirect_pc, 32'h1234);
        step();
        br_before = m_br;
        set_ex(2, 32'h308, 1'b1, 1'b1, 32'h400);
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t5_jal_no_redirect", redirect_valid, 32'd0);
        check("t5_jal_counted", perf_branches, br_before + 32'd1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            k = $urandom_range(0, 9);
            set_ex((k < 3) ? 0 : (k < 7) ? 1 : (k == 7) ? 2 : 3,
                   32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 15) << 2),
                   1'($urandom % 2), 1'($urandom % 2), $urandom & 32'hFFFF_FFFE);
            if ($urandom % 8 == 0) ex_valid = 1'b0;
            k = $urandom_range(0, 3);
            set_id(($urandom % 4) != 0, k == 1 || k == 2, k == 3,
                   32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 15) << 2));
            redirect_ready = ($urandom % 3) != 0;
        end

        // Asynchronous reset in the middle of a redirect
        step();
        set_ex(3, 32'h600, 1'b1, 1'b0, 32'hABC0);
        redirect_ready = 1'b0;
        step();
        set_ex(0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_valid", redirect_valid, 32'd0);
        check("t1_rst_pc", redirect_pc, 32'd0);
        check("t1_rst_flush_if_id", flush_if_id, 32'd0);
        check("t1_rst_flush_id_ex", flush_id_ex, 32'd0);
        check("t1_rst_branches", perf_branches, 32'd0);
        check("t1_rst_mispredicts", perf_mispredicts, 32'd0);
        for (int i = 0; i < 64; i++) begin
            set_id(1'b1, 1'b1, 1'b0, 32'(i * 4));
            #1 check("t1_rst_pred", id_pred_taken, 32'd0);
        end
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
